// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file write port arbiter for ALU and buffered memory results
// The ALU path wins the port every cycle. Memory results wait in a FIFO and drain when the ALU is idle.
module regfile_writeback #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        alu_stall,
  output logic [31:0] pending,
  output logic [4:0]  rd,
  output logic        wr,
  output logic [31:0] Din
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [AW-1:0]    head, tail;
  logic [CW-1:0]    count, next_count;
  logic [SW-1:0]    starve, next_starve;
  logic             alu_win, push, pop;

  assign mem_ready = (count < CW'(DEPTH));
  assign alu_win   = alu_valid && (alu_rd != 5'd0);
  // Writes to r0 still complete the handshake; they are simply not stored.
  assign push      = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign pop       = !alu_win && (count != '0);
  assign next_count = count + CW'(push) - CW'(pop);

  always_comb begin
    next_starve = '0;
    if ((count != '0) && alu_win) begin
      if (starve == SW'(STARVE_LIMIT))
        next_starve = starve;
      else
        next_starve = starve + SW'(1);
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i])
        pending[q_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_rd[tail]   <= mem_rd;
      q_data[tail] <= mem_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      q_valid   <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      starve    <= '0;
      alu_stall <= 1'b0;
      wr        <= 1'b0;
      rd        <= 5'd0;
      Din       <= 32'd0;
    end else begin
      if (push) begin
        q_valid[tail] <= 1'b1;
        tail          <= tail + AW'(1);
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + AW'(1);
      end
      count     <= next_count;
      starve    <= next_starve;
      alu_stall <= (next_starve == SW'(STARVE_LIMIT)) || (next_count == CW'(DEPTH));
      wr        <= alu_win || pop;
      if (alu_win) begin
        rd  <= alu_rd;
        Din <= alu_data;
      end else if (pop) begin
        rd  <= q_rd[head];
        Din <= q_data[head];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed vector bench for regfile_writeback
module tb_regfile_writeback;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic [31:0] mem_data = 32'd0;
  logic        mem_ready, alu_stall, wr;
  logic [31:0] pending, Din;
  logic [4:0]  rd;

  regfile_writeback #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready), .alu_stall(alu_stall), .pending(pending),
    .rd(rd), .wr(wr), .Din(Din)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_din;
    logic        e_ready;
    logic        e_stall;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic e_wr, input logic [4:0] e_rd, input logic [31:0] e_din,
                     input logic e_ready, input logic e_stall, input logic [31:0] e_pend);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_wr = e_wr; v.e_rd = e_rd; v.e_din = e_din;
    v.e_ready = e_ready; v.e_stall = e_stall; v.e_pend = e_pend;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string name);
    reset = v.rst; alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
    @(posedge CLK);
    #1;
    checks++;
    if ({wr, rd, Din, mem_ready, alu_stall, pending} !==
        {v.e_wr, v.e_rd, v.e_din, v.e_ready, v.e_stall, v.e_pend}) begin
      failures++;
      $display("FAIL %s: got wr=%b rd=%0d Din=%h ready=%b stall=%b pend=%h, want wr=%b rd=%0d Din=%h ready=%b stall=%b pend=%h",
               name, wr, rd, Din, mem_ready, alu_stall, pending,
               v.e_wr, v.e_rd, v.e_din, v.e_ready, v.e_stall, v.e_pend);
    end
  endtask

  initial begin
    vec_t v;
    // reset state
    add(1, 0,0,0, 0,0,0,  0,0,32'h0,        1,0,32'h0);
    add(1, 0,0,0, 0,0,0,  0,0,32'h0,        1,0,32'h0);
    // single ALU write, then idle holds rd/Din
    add(0, 1,5,32'hDEADBEEF, 0,0,0,  1,5,32'hDEADBEEF, 1,0,32'h0);
    add(0, 0,0,0, 0,0,0,             0,5,32'hDEADBEEF, 1,0,32'h0);
    // r0 suppression on both paths
    add(0, 1,0,32'h12345678, 1,0,32'h12345678, 0,5,32'hDEADBEEF, 1,0,32'h0);
    add(0, 0,0,0, 0,0,0,                       0,5,32'hDEADBEEF, 1,0,32'h0);
    // ALU priority and FIFO order
    add(0, 1,7,32'h33, 1,3,32'h11,  1,7,32'h33, 1,0,32'h8);
    add(0, 1,7,32'h33, 1,4,32'h22,  1,7,32'h33, 1,0,32'h18);
    add(0, 0,0,0, 0,0,0,            1,3,32'h11, 1,0,32'h10);
    add(0, 0,0,0, 0,0,0,            1,4,32'h22, 1,0,32'h0);
    add(0, 0,0,0, 0,0,0,            0,4,32'h22, 1,0,32'h0);
    // fill to DEPTH while the ALU blocks
    add(0, 1,9,32'h99, 1,1,32'hA1,  1,9,32'h99, 1,0,32'h2);
    add(0, 1,9,32'h99, 1,2,32'hA2,  1,9,32'h99, 1,0,32'h6);
    add(0, 1,9,32'h99, 1,3,32'hA3,  1,9,32'h99, 1,0,32'hE);
    add(0, 1,9,32'h99, 1,4,32'hA4,  1,9,32'h99, 0,1,32'h1E);
    // offered while full: must not be taken
    add(0, 0,0,0, 1,5,32'hA5,       1,1,32'hA1, 1,0,32'h1C);
    add(0, 0,0,0, 0,0,0,            1,2,32'hA2, 1,0,32'h18);
    add(0, 0,0,0, 0,0,0,            1,3,32'hA3, 1,0,32'h10);
    add(0, 0,0,0, 0,0,0,            1,4,32'hA4, 1,0,32'h0);
    add(0, 0,0,0, 0,0,0,            0,4,32'hA4, 1,0,32'h0);
    // starvation: one entry, ALU every cycle
    add(0, 1,8,32'h88, 1,6,32'h66,  1,8,32'h88, 1,0,32'h40);
    for (int k = 1; k <= 9; k++)
      add(0, 1,8,32'h88, 0,0,0,     1,8,32'h88, 1,(k >= 8),32'h40);
    add(0, 0,0,0, 0,0,0,            1,6,32'h66, 1,0,32'h0);
    add(0, 0,0,0, 0,0,0,            0,6,32'h66, 1,0,32'h0);
    // two-cycle minimum latency, simultaneous push and pop
    add(0, 0,0,0, 1,10,32'hB0,      0,6,32'h66,  1,0,32'h400);
    add(0, 0,0,0, 1,11,32'hB1,      1,10,32'hB0, 1,0,32'h800);
    add(0, 0,0,0, 0,0,0,            1,11,32'hB1, 1,0,32'h0);
    add(0, 0,0,0, 0,0,0,            0,11,32'hB1, 1,0,32'h0);
    // duplicate target keeps pending until the last entry leaves
    add(0, 1,9,32'h99, 1,12,32'hC0, 1,9,32'h99,  1,0,32'h1000);
    add(0, 1,9,32'h99, 1,12,32'hC1, 1,9,32'h99,  1,0,32'h1000);
    add(0, 0,0,0, 0,0,0,            1,12,32'hC0, 1,0,32'h1000);
    add(0, 0,0,0, 0,0,0,            1,12,32'hC1, 1,0,32'h0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a buffered drain
    add(0, 1,9,32'h99, 1,1,32'hD1,  1,9,32'h99, 1,0,32'h2);
    add(0, 1,9,32'h99, 1,2,32'hD2,  1,9,32'h99, 1,0,32'h6);
    add(0, 1,9,32'h99, 1,3,32'hD3,  1,9,32'h99, 1,0,32'hE);
    for (int i = 0; i < 3; i++) begin
      v = vecs[vecs.size() - 3 + i];
      apply(v, $sformatf("rst_fill%0d", i));
    end
    v.rst = 1; v.av = 0; v.mv = 1; v.mrd = 5; v.md = 32'hEE;
    v.e_wr = 0; v.e_rd = 0; v.e_din = 0; v.e_ready = 1; v.e_stall = 0; v.e_pend = 0;
    apply(v, "rst_edge");
    v.rst = 0; v.mv = 0; v.mrd = 0; v.md = 0;
    for (int i = 0; i < 3; i++)
      apply(v, $sformatf("rst_after%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
